// File: rtl/axi_wb_arbiter.sv
// axi_wb_arbiter: round-robin arbiter that sequences two burst-writer requesters onto one AXI4 write port.
// Rev 1.0 -- IDLE/AW/W/B sequencer with registered AW descriptor and pass-through W data.
`default_nettype none

module axi_wb_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr_0,
  input  logic [ADDR_WIDTH-1:0]   req_addr_1,
  input  logic [LEN_WIDTH-1:0]    req_len_0,
  input  logic [LEN_WIDTH-1:0]    req_len_1,
  input  logic [1:0]              data_valid,
  output logic [1:0]              data_ready,
  input  logic [DATA_WIDTH-1:0]   data_0,
  input  logic [DATA_WIDTH-1:0]   data_1,
  output logic [1:0]              done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  output logic [LEN_WIDTH-1:0]    s_axi_awlen,
  output logic [2:0]              s_axi_awsize,
  output logic [1:0]              s_axi_awburst,
  output logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  output logic [DATA_WIDTH-1:0]   s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                    s_axi_wlast,
  output logic                    s_axi_wvalid,
  input  logic                    s_axi_wready,
  input  logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_bvalid,
  output logic                    s_axi_bready,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic any_req;
  logic winner;
  logic in_idle, in_aw, in_w, in_b;
  logic last_beat;
  logic beat_fire;

  assign in_idle   = (state_q == S_IDLE);
  assign in_aw     = (state_q == S_AW);
  assign in_w      = (state_q == S_W);
  assign in_b      = (state_q == S_B);
  assign any_req   = |req_valid;
  // On a tie the requester that did not win last time gets the port.
  assign winner    = (req_valid == 2'b11) ? ~last_gnt_q : req_valid[1];
  assign last_beat = (beat_cnt_q == len_q);
  assign beat_fire = s_axi_wvalid && s_axi_wready;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d      = winner;
          last_gnt_d = winner;
          addr_d     = winner ? req_addr_1 : req_addr_0;
          len_d      = winner ? req_len_1 : req_len_0;
          beat_cnt_d = '0;
          state_d    = S_AW;
        end
      end
      S_AW: begin
        if (s_axi_awready) state_d = S_W;
      end
      S_W: begin
        if (beat_fire) begin
          if (last_beat) state_d = S_B;
          else           beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      S_B: begin
        if (s_axi_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // The accept strobe is combinational, so it is gated by reset to keep it quiet while rst is low.
  assign req_ready = (rst && in_idle && any_req) ? (winner ? 2'b10 : 2'b01) : 2'b00;

  assign s_axi_awaddr  = addr_q;
  assign s_axi_awlen   = len_q;
  assign s_axi_awsize  = 3'd2;
  assign s_axi_awburst = 2'b01;
  assign s_axi_awvalid = in_aw;

  assign s_axi_wvalid = in_w && (gnt_q ? data_valid[1] : data_valid[0]);
  assign s_axi_wdata  = in_w ? (gnt_q ? data_1 : data_0) : '0;
  assign s_axi_wstrb  = in_w ? {STRB_WIDTH{1'b1}} : '0;
  assign s_axi_wlast  = in_w && last_beat;
  assign data_ready   = in_w ? (gnt_q ? {s_axi_wready, 1'b0} : {1'b0, s_axi_wready}) : 2'b00;

  assign s_axi_bready = in_b;
  assign done         = (in_b && s_axi_bvalid) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign err          = in_b && s_axi_bvalid && (s_axi_bresp != 2'b00);
  assign busy         = !in_idle;

endmodule

`default_nettype wire
